diff_scan_unit: RTL
===================

# diff_scan_unit

Parametrised, multi-cycle successor to the 32-bit difference locator. It takes operands A and B through a valid/ready handshake and scans A^B one CHUNK-bit slice per cycle. It returns the index of the least significant differing bit, plus a flag when the operands are equal. It sits beside the ALU in the RISC datapath and serves bit-search instructions without a WIDTH-wide combinational priority chain.

## Interface
Clock is `clk`; reset is `rst`, asynchronous and active-high. The polarity and synchronicity are fixed.

Parameters:
- WIDTH, 32: operand width; must be ≥2 and a multiple of CHUNK.
- CHUNK, 8: bits examined per scan cycle; must be a power of 2.
- IW, $clog2(WIDTH): derived index width; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit accepts operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- mode  in  1  search direction; present only with DIFF_SCAN_MSB_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- LSB  out  IW  bit index of the found difference.
- no_diff  out  1  A == B.

## Operation
- States:
  - IDLE: in_ready=1.
  - SCAN: walks chunk counter k = 0..NCH-1, where NCH = WIDTH/CHUNK.
  - DONE: out_valid=1.
- IDLE → SCAN on in_valid && in_ready:
  - register X = A^B;
  - clear k;
  - latch mode, when compiled in.
- SCAN, each cycle:
  - If chunk X[k*CHUNK +: CHUNK] ≠ 0: LSB ← k*CHUNK + (lowest set bit position within the chunk); no_diff ← 0; go to DONE.
  - Else if k == NCH-1: LSB ← 0; no_diff ← 1; go to DONE.
  - Else: k ← k+1.
- DONE: LSB and no_diff are held stable. On out_ready, go to IDLE. No new operand is accepted in the same cycle.
- in_valid is ignored outside IDLE. A and B are sampled only on the handshake edge and may change afterward.
- Arithmetic rules:
  - index = k*CHUNK + offset, computed in IW bits;
  - it never overflows, since the maximum is WIDTH-1.
- Reset:
  - state=IDLE, k=0, X=0, LSB=0, no_diff=0, out_valid=0.
  - in_ready=0 while rst is high, and 1 on the first cycle after release.
  - Reset asserted mid-SCAN or in DONE aborts the operation immediately; no result is emitted.

## Timing
- Capture on edge E0.
- A difference first found in chunk k raises out_valid after edge E(k+1): latency k+1 cycles.
- An equal-operand result appears after edge E(NCH), i.e. NCH cycles later.
- Worst case for the defaults is 4 cycles.
- Throughput is one operation per latency+2 cycles at minimum: capture, scan, DONE, return to IDLE.
- out_valid, LSB, no_diff and in_ready are functions of registered state only. No combinational path exists from inputs to outputs.

## Configuration
- DIFF_SCAN_MSB_EN, defined:
  - adds the `mode` port;
  - mode=1 scans chunks from k=NCH-1 down to 0;
  - reports the highest set bit within the first nonzero chunk, i.e. the most significant differing bit;
  - equal-operand result is the same as for mode=0;
  - mode=0 behaves exactly as the undefined case.
- DIFF_SCAN_MSB_EN, undefined: no `mode` port; LSB-first search only.

## Structure
- Package diff_scan_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - a localparam for the state encoding width.
- Sub-module diff_chunk_enc:
  - CHUNK-wide priority encoder with direction input;
  - outputs offset [$clog2(CHUNK)-1:0] and nonzero flag;
  - instantiated once, fed by a mux on k.

## Test plan
Defaults WIDTH=32, CHUNK=8 unless stated.
- A=0x4, B=0x8 → LSB=2, no_diff=0, out_valid 1 cycle after capture.
- A=0x30, B=0x3F → LSB=0 after 1 cycle. With MSB_EN and mode=1 → LSB=3 after 4 cycles.
- A=0x1000_0000, B=0 → LSB=28, out_valid 4 cycles after capture.
- A=B=0xDEADBEEF → no_diff=1, LSB=0 after 4 cycles.
- Backpressure: out_ready held low for 5 cycles with in_valid pulsed → outputs stable, in_ready=0, no second capture. After out_ready, the unit returns to IDLE and in_ready=1 on the next cycle.
- Reset asserted 2 cycles into SCAN → out_valid=0, LSB=0 immediately. A new op A=1, B=0 then gives LSB=0. Rerun at WIDTH=64, CHUNK=16 with A=1<<63 → LSB=63.

Source files
------------

// File: rtl/diff_scan_pkg.sv
// Shared types for the diff_scan_unit chunked difference locator.
package diff_scan_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

endpackage

// File: rtl/diff_chunk_enc.sv
// Combinational CHUNK-wide priority encoder; msb_first_i selects the
// highest set bit instead of the lowest.
module diff_chunk_enc #(
    parameter  int unsigned CHUNK = 8,
    localparam int unsigned OW    = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] chunk_i,
    input  logic             msb_first_i,
    output logic [OW-1:0]    offset_o,
    output logic             nonzero_o
);

    // Last match in loop order wins, so the scan direction picks the priority.
    always_comb begin
        offset_o  = '0;
        nonzero_o = |chunk_i;
        if (msb_first_i) begin
            for (int i = 0; i < int'(CHUNK); i++) begin
                if (chunk_i[i]) offset_o = OW'(i);
            end
        end else begin
            for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
                if (chunk_i[i]) offset_o = OW'(i);
            end
        end
    end

endmodule

// File: rtl/diff_scan_unit.sv
// Multi-cycle locator of the lowest (optionally highest) differing bit of A and B,
// one CHUNK slice per cycle. Define DIFF_SCAN_MSB_EN to add the MSB-first mode port.
module diff_scan_unit
    import diff_scan_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned CHUNK = 8,
    localparam int unsigned IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIFF_SCAN_MSB_EN
    input  logic             mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    LSB,
    output logic             no_diff
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned OW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             mode_q, mode_d;
    logic [IW-1:0]    lsb_q, lsb_d;
    logic             no_diff_q, no_diff_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             mode_in_c;
    logic [CHUNK-1:0] chunk_c;
    logic [OW-1:0]    offset_c;
    logic             nonzero_c;
    logic             last_c;
    logic [IW-1:0]    index_c;

`ifdef DIFF_SCAN_MSB_EN
    assign mode_in_c = mode;
`else
    assign mode_in_c = 1'b0;
`endif

    // Chunk select on k feeding the single shared encoder.
    always_comb begin
        chunk_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (k_q == KW'(i)) chunk_c = x_q[i*CHUNK +: CHUNK];
        end
    end

    diff_chunk_enc #(
        .CHUNK(CHUNK)
    ) u_enc (
        .chunk_i    (chunk_c),
        .msb_first_i(mode_q),
        .offset_o   (offset_c),
        .nonzero_o  (nonzero_c)
    );

    assign index_c = IW'(k_q) * IW'(CHUNK) + IW'(offset_c);
    assign last_c  = mode_q ? (k_q == '0) : (k_q == KW'(NCH - 1));

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        mode_d      = mode_q;
        lsb_d       = lsb_q;
        no_diff_d   = no_diff_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = A ^ B;
                    mode_d  = mode_in_c;
                    k_d     = mode_in_c ? KW'(NCH - 1) : '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (nonzero_c) begin
                    lsb_d     = index_c;
                    no_diff_d = 1'b0;
                    state_d   = DONE;
                end else if (last_c) begin
                    lsb_d     = '0;
                    no_diff_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    k_d = mode_q ? (k_q - KW'(1)) : (k_q + KW'(1));
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state.
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            mode_q      <= 1'b0;
            lsb_q       <= '0;
            no_diff_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            mode_q      <= mode_d;
            lsb_q       <= lsb_d;
            no_diff_q   <= no_diff_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign LSB       = lsb_q;
    assign no_diff   = no_diff_q;

endmodule
